// File: rtl/lh_ecdsa_arb_pkg.sv
// ----------------------------------------------------------------------------
// lh_ecdsa_arb_pkg
//
// Purpose:
//   Shared types and constants for the lookup-header ECDSA verify scheduler.
//   - lh_ecdsa_meta_type      : head-entry metadata of an sfifo_lh_ecdsa FIFO,
//                               forwarded unchanged to the verify engine.
//   - lh_ecdsa_arb_state_type : scheduler FSM encoding (2-bit state register).
//   - LH_ECDSA_ARB_*_DEF      : default parameter values for lh_ecdsa_arb.
//   - lh_ecdsa_sat_inc32      : saturating 32-bit increment for the optional
//                               statistics counters.
//
// Ports: none (package).
// ----------------------------------------------------------------------------
package lh_ecdsa_arb_pkg;

    // Default log2 of the number of request sources (4 sources).
    localparam int LH_ECDSA_ARB_SRC_NBITS_DEF  = 2;

    // Default credit width (8 outstanding engine jobs).
    localparam int LH_ECDSA_ARB_CRED_NBITS_DEF = 3;

    // Metadata carried from the lookup-header FIFO to the verify engine.
    typedef struct packed {
        logic [15:0] flow_id;   // lookup flow handle
        logic [7:0]  key_sel;   // public-key table index
        logic [7:0]  sig_len;   // signature length in bytes
    } lh_ecdsa_meta_type;

    localparam int LH_ECDSA_META_W = $bits(lh_ecdsa_meta_type);

    // Scheduler FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_STALL = 2'd2
    } lh_ecdsa_arb_state_type;

    // Saturating increment: holds at all-ones instead of wrapping to zero.
    function automatic logic [31:0] lh_ecdsa_sat_inc32(input logic [31:0] value);
        logic [31:0] result;
        if (value == 32'hFFFF_FFFF) begin
            result = value;
        end else begin
            result = value + 32'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/lh_ecdsa_rr_pick.sv
// ----------------------------------------------------------------------------
// lh_ecdsa_rr_pick
//
// Purpose:
//   Purely combinational round-robin picker. Selects the first asserted
//   request strictly after i_ptr, searching upward modulo NUM_SRC, so the
//   source at i_ptr itself is considered last.
//
// Parameters:
//   SRC_NBITS : log2 of the number of sources; NUM_SRC = 1 << SRC_NBITS.
//
// Ports:
//   i_req     in   NUM_SRC     request vector (1 = source has an entry)
//   i_ptr     in   SRC_NBITS   index of the most recently granted source
//   o_gnt     out  NUM_SRC     one-hot grant, all zero when nothing requests
//   o_gnt_idx out  SRC_NBITS   index of the granted source (0 when none)
//   o_any     out  1           at least one request is asserted
// ----------------------------------------------------------------------------
module lh_ecdsa_rr_pick #(
    parameter  int SRC_NBITS = 2,
    localparam int NUM_SRC   = 1 << SRC_NBITS
) (
    input  logic [NUM_SRC-1:0]   i_req,
    input  logic [SRC_NBITS-1:0] i_ptr,
    output logic [NUM_SRC-1:0]   o_gnt,
    output logic [SRC_NBITS-1:0] o_gnt_idx,
    output logic                 o_any
);

    logic                 w_found;
    logic [SRC_NBITS-1:0] w_idx;

    always_comb begin
        o_gnt     = '0;
        o_gnt_idx = '0;
        w_found   = 1'b0;
        w_idx     = '0;
        // Offsets 1..NUM_SRC; the SRC_NBITS-wide add wraps from NUM_SRC-1
        // back to 0, and offset NUM_SRC lands on i_ptr itself.
        for (int k = 1; k <= NUM_SRC; k++) begin
            w_idx = i_ptr + SRC_NBITS'(k);
            if (!w_found && i_req[w_idx]) begin
                w_found   = 1'b1;
                o_gnt_idx = w_idx;
            end
        end
        o_gnt[o_gnt_idx] = w_found;
        o_any            = |i_req;
    end

endmodule

// File: rtl/lh_ecdsa_arb.sv
// ----------------------------------------------------------------------------
// lh_ecdsa_arb
//
// Purpose:
//   Round-robin scheduler sharing one ECDSA verify engine among NUM_SRC
//   lookup-header ECDSA meta FIFOs (sfifo_lh_ecdsa). At most one FIFO entry
//   is popped per cycle and forwarded, one cycle later, with its source id.
//   The number of jobs in flight at the engine is bounded by a credit
//   counter; each engine done pulse returns one credit.
//
// Parameters:
//   SRC_NBITS  : log2 of source count; NUM_SRC = 1 << SRC_NBITS
//   CRED_NBITS : credit width; MAX_CRED = 1 << CRED_NBITS
//
// Optional feature (compile-time macro LH_ECDSA_ARB_STATS_EN):
//   defined   -> adds o_grant_cnt[NUM_SRC] (per-source grant counters) and
//                o_stall_cnt (cycles in ST_STALL with a request pending),
//                both 32-bit, reset to 0 and saturating at all-ones.
//   undefined -> those ports and counters are absent; nothing else changes.
//
// Ports:
//   i_clk          in   1              clock
//   i_rst_n        in   1              asynchronous active-low reset
//   i_enable       in   1              0 = no new grants; in-flight jobs retire
//   i_req_empty    in   NUM_SRC        per-source FIFO empty
//   i_req_meta     in   NUM_SRC x meta per-source FIFO head entry
//   o_req_rd       out  NUM_SRC        per-source FIFO pop, one-hot or zero,
//                                      combinational
//   o_ecdsa_valid  out  1              registered one-cycle job pulse
//   o_ecdsa_meta   out  meta           registered job metadata
//   o_ecdsa_src    out  SRC_NBITS      registered source id of the job
//   i_ecdsa_done   in   1              engine completion, returns one credit
//   o_cred_avail   out  CRED_NBITS+1   registered free credits
//   o_busy         out  1              registered; credits outstanding or a
//                                      grant was issued in the last cycle
//   o_state        out  2              scheduler FSM state (debug)
//   o_grant_cnt    out  NUM_SRC x 32   (stats build only)
//   o_stall_cnt    out  32             (stats build only)
//
// Handshake: o_req_rd[g] is a pop strobe for FIFO g, asserted only while
//   that FIFO is non-empty; the FIFO advances its head on the clock edge
//   that ends the cycle in which o_req_rd[g] is high. o_ecdsa_valid is a
//   push-only pulse: the engine has no back-pressure, the credit counter
//   guarantees it never holds more than MAX_CRED jobs.
// ----------------------------------------------------------------------------
module lh_ecdsa_arb
    import lh_ecdsa_arb_pkg::*;
#(
    parameter  int SRC_NBITS  = LH_ECDSA_ARB_SRC_NBITS_DEF,
    parameter  int CRED_NBITS = LH_ECDSA_ARB_CRED_NBITS_DEF,
    localparam int NUM_SRC    = 1 << SRC_NBITS
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_enable,
    input  logic [NUM_SRC-1:0]     i_req_empty,
    input  lh_ecdsa_meta_type      i_req_meta [NUM_SRC],
    output logic [NUM_SRC-1:0]     o_req_rd,
    output logic                   o_ecdsa_valid,
    output lh_ecdsa_meta_type      o_ecdsa_meta,
    output logic [SRC_NBITS-1:0]   o_ecdsa_src,
    input  logic                   i_ecdsa_done,
    output logic [CRED_NBITS:0]    o_cred_avail,
    output logic                   o_busy,
    output lh_ecdsa_arb_state_type o_state
`ifdef LH_ECDSA_ARB_STATS_EN
    ,
    output logic [31:0]            o_grant_cnt [NUM_SRC],
    output logic [31:0]            o_stall_cnt
`endif
);

    localparam logic [CRED_NBITS:0] MAX_CRED = {1'b1, {CRED_NBITS{1'b0}}};
    localparam logic [CRED_NBITS:0] CRED_ONE = {{CRED_NBITS{1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    lh_ecdsa_arb_state_type r_state;
    lh_ecdsa_arb_state_type w_state_nxt;
    logic [CRED_NBITS:0]    r_cred;
    logic [CRED_NBITS:0]    w_cred_nxt;
    logic [SRC_NBITS-1:0]   r_rr_ptr;
    logic                   r_ecdsa_valid;
    lh_ecdsa_meta_type      r_ecdsa_meta;
    logic [SRC_NBITS-1:0]   r_ecdsa_src;
    logic                   r_busy;

    // ------------------------------------------------------------------
    // Round-robin pick among non-empty sources
    // ------------------------------------------------------------------
    logic [NUM_SRC-1:0]     w_req;
    logic [NUM_SRC-1:0]     w_gnt;
    logic [SRC_NBITS-1:0]   w_gnt_idx;
    logic                   w_any;
    logic                   w_grant;
    logic                   w_done_eff;

    assign w_req = ~i_req_empty;

    lh_ecdsa_rr_pick #(
        .SRC_NBITS (SRC_NBITS)
    ) u_rr_pick (
        .i_req     (w_req),
        .i_ptr     (r_rr_ptr),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx),
        .o_any     (w_any)
    );

    // The grant is decided from this cycle's state and credits only, so a
    // done pulse that frees a credit in ST_STALL can be used no earlier than
    // the following cycle. i_rst_n is folded in so no FIFO is ever popped
    // while the block is held in reset.
    assign w_grant = i_rst_n
                   & i_enable
                   & (r_state != ST_STALL)
                   & w_any
                   & (r_cred != '0);

    assign o_req_rd = w_grant ? w_gnt : '0;

    // A done pulse with every credit already home has no job to retire and
    // is dropped rather than overflowing the counter.
    assign w_done_eff = i_ecdsa_done & (r_cred != MAX_CRED);

    // ------------------------------------------------------------------
    // Credit arithmetic: grant and done in the same cycle cancel out.
    // ------------------------------------------------------------------
    always_comb begin
        w_cred_nxt = r_cred;
        if (w_grant) begin
            w_cred_nxt = w_cred_nxt - CRED_ONE;
        end
        if (w_done_eff) begin
            w_cred_nxt = w_cred_nxt + CRED_ONE;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state
    //   ST_IDLE  : no grant in the previous cycle; a grant moves to ISSUE.
    //   ST_ISSUE : streaming grants; exhausting credits wins over running
    //              out of requests so the FSM parks in STALL until a done.
    //   ST_STALL : grants blocked until the engine returns a credit.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_grant) begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (w_cred_nxt == '0) begin
                    w_state_nxt = ST_STALL;
                end else if (!w_any || !i_enable) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_STALL: begin
                if (i_ecdsa_done) begin
                    w_state_nxt = w_any ? ST_ISSUE : ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= ST_IDLE;
            r_cred        <= MAX_CRED;
            r_rr_ptr      <= SRC_NBITS'(NUM_SRC - 1);
            r_ecdsa_valid <= 1'b0;
            r_ecdsa_meta  <= '0;
            r_ecdsa_src   <= '0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cred        <= w_cred_nxt;
            r_ecdsa_valid <= w_grant;
            r_busy        <= w_grant | (w_cred_nxt != MAX_CRED);
            if (w_grant) begin
                r_ecdsa_meta <= i_req_meta[w_gnt_idx];
                r_ecdsa_src  <= w_gnt_idx;
                r_rr_ptr     <= w_gnt_idx;
            end
        end
    end

    assign o_ecdsa_valid = r_ecdsa_valid;
    assign o_ecdsa_meta  = r_ecdsa_meta;
    assign o_ecdsa_src   = r_ecdsa_src;
    assign o_cred_avail  = r_cred;
    assign o_busy        = r_busy;
    assign o_state       = r_state;

`ifdef LH_ECDSA_ARB_STATS_EN
    // ------------------------------------------------------------------
    // Optional statistics
    // ------------------------------------------------------------------
    logic [31:0] r_grant_cnt [NUM_SRC];
    logic [31:0] r_stall_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int s = 0; s < NUM_SRC; s++) begin
                r_grant_cnt[s] <= '0;
            end
            r_stall_cnt <= '0;
        end else begin
            for (int s = 0; s < NUM_SRC; s++) begin
                if (o_req_rd[s]) begin
                    r_grant_cnt[s] <= lh_ecdsa_sat_inc32(r_grant_cnt[s]);
                end
            end
            if ((r_state == ST_STALL) && w_any) begin
                r_stall_cnt <= lh_ecdsa_sat_inc32(r_stall_cnt);
            end
        end
    end

    assign o_grant_cnt = r_grant_cnt;
    assign o_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_lh_ecdsa_arb.sv
// ----------------------------------------------------------------------------
// tb_lh_ecdsa_arb
//
// Directed bench for lh_ecdsa_arb (defaults: 4 sources, 8 credits). The
// source FIFOs are modelled in the bench; every entry expected to reach the
// engine is queued in exp_q when it is loaded, and popped when the DUT
// raises o_ecdsa_valid. Inputs change 1 time unit after the rising edge,
// outputs are sampled 1 (registered) or 3 (combinational) units after it.
// ----------------------------------------------------------------------------
module tb_lh_ecdsa_arb;
    import lh_ecdsa_arb_pkg::*;

    localparam int SRC_NBITS = 2;
    localparam int NUM_SRC   = 4;
    localparam int JOB_W     = SRC_NBITS + LH_ECDSA_META_W;
    localparam int FDEPTH    = 16;

    // ------------------------------------------------------------------
    // DUT signals
    // ------------------------------------------------------------------
    logic                   i_clk;
    logic                   i_rst_n;
    logic                   i_enable;
    logic [NUM_SRC-1:0]     i_req_empty;
    lh_ecdsa_meta_type      i_req_meta [NUM_SRC];
    logic [NUM_SRC-1:0]     o_req_rd;
    logic                   o_ecdsa_valid;
    lh_ecdsa_meta_type      o_ecdsa_meta;
    logic [SRC_NBITS-1:0]   o_ecdsa_src;
    logic                   i_ecdsa_done;
    logic [3:0]             o_cred_avail;
    logic                   o_busy;
    lh_ecdsa_arb_state_type o_state;
`ifdef LH_ECDSA_ARB_STATS_EN
    logic [31:0]            o_grant_cnt [NUM_SRC];
    logic [31:0]            o_stall_cnt;
`endif

    lh_ecdsa_arb #(
        .SRC_NBITS  (SRC_NBITS),
        .CRED_NBITS (3)
    ) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_enable      (i_enable),
        .i_req_empty   (i_req_empty),
        .i_req_meta    (i_req_meta),
        .o_req_rd      (o_req_rd),
        .o_ecdsa_valid (o_ecdsa_valid),
        .o_ecdsa_meta  (o_ecdsa_meta),
        .o_ecdsa_src   (o_ecdsa_src),
        .i_ecdsa_done  (i_ecdsa_done),
        .o_cred_avail  (o_cred_avail),
        .o_busy        (o_busy),
        .o_state       (o_state)
`ifdef LH_ECDSA_ARB_STATS_EN
        ,
        .o_grant_cnt   (o_grant_cnt),
        .o_stall_cnt   (o_stall_cnt)
`endif
    );

    // ------------------------------------------------------------------
    // Clock
    // ------------------------------------------------------------------
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // ------------------------------------------------------------------
    // Bench state: FIFO model, scoreboard, counters
    // ------------------------------------------------------------------
    lh_ecdsa_meta_type  fmem [NUM_SRC][FDEPTH];
    int                 fhead [NUM_SRC];
    int                 ftail [NUM_SRC];
    logic [JOB_W-1:0]   exp_q [$];
    logic [NUM_SRC-1:0] last_rd;
    int                 n_checks;
    int                 n_fail;
    logic [31:0]        m6;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_fifo();
        for (int s = 0; s < NUM_SRC; s++) begin
            i_req_empty[s] = (fhead[s] == ftail[s]);
            i_req_meta[s]  = (fhead[s] == ftail[s]) ? '0 : fmem[s][fhead[s] % FDEPTH];
        end
    endtask

    task automatic push_entry(input int s, input logic [31:0] m, input bit expect_job);
        fmem[s][ftail[s] % FDEPTH] = lh_ecdsa_meta_type'(m);
        ftail[s]++;
        if (expect_job) begin
            exp_q.push_back({SRC_NBITS'(s), m});
        end
        drive_fifo();
    endtask

    // One clock cycle: sample the combinational pop, let the edge happen,
    // advance the FIFO model and score any job the DUT issued.
    task automatic tick();
        logic [JOB_W-1:0] exp_job;
        drive_fifo();
        #2;
        last_rd = o_req_rd;
        check("rd_only_nonempty", 64'(o_req_rd & i_req_empty), 64'd0);
        @(posedge i_clk);
        #1;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (last_rd[s]) fhead[s]++;
        end
        if (o_ecdsa_valid) begin
            if (exp_q.size() == 0) begin
                check("job_was_expected", 64'(exp_q.size()), 64'd1);
            end else begin
                exp_job = exp_q.pop_front();
                check("job", 64'({o_ecdsa_src, o_ecdsa_meta}), 64'(exp_job));
            end
        end
        drive_fifo();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd"},    64'(o_req_rd),      64'd0);
        check({tag, "_valid"}, 64'(o_ecdsa_valid), 64'd0);
        check({tag, "_meta"},  64'(o_ecdsa_meta),  64'd0);
        check({tag, "_src"},   64'(o_ecdsa_src),   64'd0);
        check({tag, "_cred"},  64'(o_cred_avail),  64'd8);
        check({tag, "_busy"},  64'(o_busy),        64'd0);
        check({tag, "_state"}, 64'(o_state),       64'(ST_IDLE));
`ifdef LH_ECDSA_ARB_STATS_EN
        for (int s = 0; s < NUM_SRC; s++) begin
            check({tag, "_grant_cnt"}, 64'(o_grant_cnt[s]), 64'd0);
        end
        check({tag, "_stall_cnt"}, 64'(o_stall_cnt), 64'd0);
`endif
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        n_checks     = 0;
        n_fail       = 0;
        i_rst_n      = 1'b0;
        i_enable     = 1'b1;
        i_ecdsa_done = 1'b0;
        for (int s = 0; s < NUM_SRC; s++) begin
            fhead[s] = 0;
            ftail[s] = 0;
        end
        drive_fifo();

        // Test 1 stimulus loaded while reset is held: two entries per source,
        // loaded in the order the round robin must serve them.
        for (int e = 0; e < 2; e++) begin
            for (int s = 0; s < NUM_SRC; s++) begin
                push_entry(s, $urandom(), 1'b1);
            end
        end
        repeat (2) @(posedge i_clk);
        #3;
        check_reset_outputs("reset");
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;

        // Test 1: all sources busy, no done -> 0,1,2,3,0,1,2,3 then stall.
        for (int i = 0; i < 8; i++) begin
            tick();
            check("t1_order", 64'(last_rd), 64'd1 << (i % 4));
            check("t1_valid", 64'(o_ecdsa_valid), 64'd1);
        end
        check("t1_cred_zero", 64'(o_cred_avail), 64'd0);
        check("t1_state",     64'(o_state), 64'(ST_STALL));
        check("t1_busy",      64'(o_busy), 64'd1);
`ifdef LH_ECDSA_ARB_STATS_EN
        for (int s = 0; s < NUM_SRC; s++) begin
            check("t1_grant_cnt", 64'(o_grant_cnt[s]), 64'd2);
        end
`endif

        // Test 3: stalled with a request; done at t frees a credit, grant t+1.
        push_entry(1, $urandom(), 1'b1);
        tick();
        check("t3_hold_rd",    64'(last_rd), 64'd0);
        check("t3_hold_state", 64'(o_state), 64'(ST_STALL));
        check("t3_hold_valid", 64'(o_ecdsa_valid), 64'd0);
        i_ecdsa_done = 1'b1;
        tick();
        i_ecdsa_done = 1'b0;
        check("t3_done_rd",    64'(last_rd), 64'd0);
        check("t3_cred_t1",    64'(o_cred_avail), 64'd1);
        check("t3_state_t1",   64'(o_state), 64'(ST_ISSUE));
`ifdef LH_ECDSA_ARB_STATS_EN
        check("t3_stall_cnt",  64'(o_stall_cnt), 64'd2);
`endif
        tick();
        check("t3_grant_rd",   64'(last_rd), 64'b0010);
        check("t3_valid_t2",   64'(o_ecdsa_valid), 64'd1);
        check("t3_cred_t2",    64'(o_cred_avail), 64'd0);
        check("t3_state_t2",   64'(o_state), 64'(ST_STALL));

        // Return all eight credits, then one surplus done that must be dropped.
        i_ecdsa_done = 1'b1;
        repeat (8) tick();
        check("ret_cred_full", 64'(o_cred_avail), 64'd8);
        tick();
        i_ecdsa_done = 1'b0;
        check("done_at_max",   64'(o_cred_avail), 64'd8);
        check("idle_busy",     64'(o_busy), 64'd0);
        check("idle_state",    64'(o_state), 64'(ST_IDLE));

        // Test 2: only source 2, three entries, back-to-back pops.
        for (int i = 0; i < 3; i++) push_entry(2, $urandom(), 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t2_rd",    64'(last_rd), 64'b0100);
            check("t2_valid", 64'(o_ecdsa_valid), 64'd1);
            check("t2_src",   64'(o_ecdsa_src), 64'd2);
        end
        tick();
        check("t2_drained_rd",    64'(last_rd), 64'd0);
        check("t2_drained_valid", 64'(o_ecdsa_valid), 64'd0);
        check("t2_cred",          64'(o_cred_avail), 64'd5);

        // Bring credits down to 3 with two grants to source 0.
        push_entry(0, $urandom(), 1'b1);
        push_entry(0, $urandom(), 1'b1);
        repeat (2) begin
            tick();
            check("fill_rd", 64'(last_rd), 64'b0001);
        end
        check("fill_cred", 64'(o_cred_avail), 64'd3);

        // Test 4: grant and done in the same cycle leave credits at 3.
        push_entry(1, $urandom(), 1'b1);
        i_ecdsa_done = 1'b1;
        tick();
        i_ecdsa_done = 1'b0;
        check("t4_rd",   64'(last_rd), 64'b0010);
        check("t4_cred", 64'(o_cred_avail), 64'd3);

        // Test 5: enable low with sources 1 and 3 pending (rr_ptr = 1).
        push_entry(3, $urandom(), 1'b1);
        push_entry(1, $urandom(), 1'b1);
        i_enable = 1'b0;
        repeat (2) begin
            tick();
            check("t5_off_rd",    64'(last_rd), 64'd0);
            check("t5_off_valid", 64'(o_ecdsa_valid), 64'd0);
        end
        check("t5_off_state", 64'(o_state), 64'(ST_IDLE));
        i_enable = 1'b1;
        tick();
        check("t5_first_src3", 64'(last_rd), 64'b1000);
        tick();
        check("t5_then_src1",  64'(last_rd), 64'b0010);
        check("t5_cred",       64'(o_cred_avail), 64'd1);

        // Test 6: reset with four jobs in flight.
        i_ecdsa_done = 1'b1;
        repeat (4) tick();
        i_ecdsa_done = 1'b0;
        check("t6_pre_cred", 64'(o_cred_avail), 64'd5);
        push_entry(0, $urandom(), 1'b1);
        tick();
        check("t6_grant_rd",  64'(last_rd), 64'b0001);
        check("t6_inflight",  64'(o_cred_avail), 64'd4);
        m6 = $urandom();
        push_entry(2, m6, 1'b0);
        i_rst_n = 1'b0;
        #1;
        check_reset_outputs("t6_async");
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        check("t6_cred_release", 64'(o_cred_avail), 64'd8);
        // rr_ptr is back at 3, so the pending source 2 entry goes next.
        exp_q.push_back({SRC_NBITS'(2), m6});
        tick();
        check("t6_post_rd",  64'(last_rd), 64'b0100);
        check("t6_post_src", 64'(o_ecdsa_src), 64'd2);
        tick();
        check("t6_idle_rd",  64'(last_rd), 64'd0);

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
